matrix_host: RTL and testbench
==============================

# matrix_host

Host-side driver for the serial 3x3 matrix multiplier interface. It holds the two operand matrices written by a configuration port and issues the start pulse. It serialises the 18 operand bytes onto the multiplier's byte input, then captures the nine 16-bit results streamed back and exposes them through a random-access read port. It sits between the system control logic and the multiplier, and is the only agent driving the multiplier's `start`/`in` pins.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles without `mm_done` before aborting.
- `DATA_W`, 8: operand element width; result width is `2*DATA_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset; all state clears while low.
- `cfg_we` in 1: operand write strobe.
- `cfg_addr` in 5: 0-8 = A row-major, 9-17 = B row-major.
- `cfg_wdata` in 8: operand byte.
- `go` in 1: request a multiply; sampled only in IDLE.
- `busy` out 1: high from the cycle after accepted `go` until results are posted or timeout.
- `mm_start` out 1: start pulse to the multiplier.
- `mm_in` out 8: operand byte stream to the multiplier.
- `mm_o` in 16: result stream from the multiplier.
- `mm_done` in 1: multiplier done flag.
- `res_addr` in 4: result index 0-8, row-major C.
- `res_data` out 16: combinational read of result `res_addr`; 0 for addresses 9-15.
- `res_valid` out 1: result file holds a complete, fresh result set.
- `timeout` out 1: sticky error from the last run; cleared by the next accepted `go`.

## Operation
- Operand memory: 18 x 8 bits. Writes are accepted only when `busy`=0 and `cfg_addr`<18; otherwise they are ignored.
- States:
  - IDLE: `go`=1 → START. Entering START clears `res_valid` and `timeout`.
  - START: 1 cycle, `mm_start`=1 → SEND, index=0.
  - SEND: 18 cycles, `mm_in`=mem[index], index increments. After index 17 → WAIT, with the wait counter at 0.
  - WAIT: `mm_in`=0. The capture shift register samples `mm_o` every cycle.
    - Sampled `mm_done`=1 → POST.
    - Wait counter reaching `TIMEOUT_CYCLES`-1 without done → IDLE, with `timeout`=1 and `res_valid`=0.
  - POST: 1 cycle. Copy the 9-deep capture register into the result file, oldest sample to index 0. Set `res_valid`=1 → IDLE.
- Capture alignment: the peer presents C[0..8] on `mm_o` on 9 consecutive cycles, and `mm_done` rises in the same cycle as C[8]. The last 9 samples at the done edge are therefore exactly C[0..8].
- Arithmetic: none in this block. Results are stored as received; any 16-bit wrap is the peer's.
- Output drive:
  - `mm_start` is high only in START.
  - `mm_in` is 0 outside SEND.
  - `busy` is high in START, SEND, WAIT and POST.
- Reset (including mid-run) values:
  - Outputs: `busy`=0, `mm_start`=0, `mm_in`=0, `res_valid`=0, `timeout`=0; `res_data` reads 0.
  - Internal state: operand memory, result file and capture register are all 0.
  - State returns to IDLE.

## Timing
- `go` is sampled at the edge ending cycle 0; from that edge the block runs:
  - cycle 1: `mm_start`=1 and `busy`=1.
  - cycles 2-19: bytes 0-17 on `mm_in`.
  - cycle 20 on: WAIT.
- With a conforming peer:
  - C[0..8] appear on `mm_o` in cycles 23-31, with `mm_done`=1 in cycle 31.
  - Cycle 32 is POST.
  - In cycle 33: `res_valid`=1, `busy`=0, results readable.
  - A new `go` is accepted in cycle 33.
- The peer's stale `mm_done` from the previous run has cleared before the next WAIT is reached (≥20 cycles), so no extra qualification is required.
- `go` held high is re-accepted every time IDLE is reached; this gives back-to-back runs.
- A `cfg_we` in the same cycle as an accepted `go` is written (block still IDLE); operands are read from memory in SEND.

## Structure
- Shared package `matrix_pkg`:
  - constants `MAT_N`=3, `MAT_ELEMS`=9, `LOAD_BYTES`=18.
  - state enum (IDLE, START, SEND, WAIT, POST).
  - operand/result width localparams, also used by the multiplier.
- Sub-module `mm_result_capture`:
  - 9 x 16 shift register with enable.
  - parallel 9-word output.
  - instantiated once.

## Test plan
- A = identity, B = 1..9, `go` against the multiplier model → result indices 0-8 read 1..9; `res_valid` rises in cycle 33.
- A = B = all 255 → every result reads 64003 (195075 mod 65536).
- Multiplier held in reset (no `mm_done`) → `timeout`=1 and `busy`=0 exactly 64 cycles after WAIT entry; `res_valid`=0.
- `cfg_we` to address 5 with 0xAA during SEND, plus a write to address 20 while IDLE → memory unchanged; results match the original operands.
- `reset` low in cycle 10 of SEND → all outputs 0 next cycle. After release, a fresh `go` with new operands yields correct results.
- `go` held high for two runs with B changed in between → second result set reflects new B; `res_valid` low during the second run.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, widths and state encoding for the 3x3 matrix host and
// its serial multiplier peer.
package matrix_pkg;
  localparam int MAT_N      = 3;
  localparam int MAT_ELEMS  = MAT_N * MAT_N;
  localparam int LOAD_BYTES = 2 * MAT_ELEMS;
  localparam int OPND_W     = 8;
  localparam int RES_W      = 2 * OPND_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_WAIT,
    ST_POST
  } state_t;
endpackage

// File: rtl/mm_result_capture.sv
// Result capture shift register: newest sample enters at the top index, so
// after DEPTH shifts index 0 holds the oldest word.
module mm_result_capture #(
  parameter int W     = 16,
  parameter int DEPTH = 9
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [W-1:0]              i_din,
  output logic [DEPTH-1:0][W-1:0]   o_words
);
  logic [DEPTH-1:0][W-1:0] r_sh;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_sh <= '0;
    else if (i_en) r_sh <= {i_din, r_sh[DEPTH-1:1]};
  end

  assign o_words = r_sh;
endmodule

// File: rtl/matrix_host.sv
// Host-side driver for the serial 3x3 multiplier: holds operands, streams them
// out after a start pulse, captures the nine results and serves them by index.
module matrix_host
  import matrix_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [4:0]          cfg_addr,
  input  logic [DATA_W-1:0]   cfg_wdata,
  input  logic                go,
  output logic                busy,
  output logic                mm_start,
  output logic [DATA_W-1:0]   mm_in,
  input  logic [2*DATA_W-1:0] mm_o,
  input  logic                mm_done,
  input  logic [3:0]          res_addr,
  output logic [2*DATA_W-1:0] res_data,
  output logic                res_valid,
  output logic                timeout
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                               r_state, w_next;
  logic [4:0]                           r_idx;
  logic [CW-1:0]                        r_wcnt;
  logic [LOAD_BYTES-1:0][DATA_W-1:0]    r_mem;
  logic [MAT_ELEMS-1:0][2*DATA_W-1:0]   r_res;
  logic [MAT_ELEMS-1:0][2*DATA_W-1:0]   w_cap;
  logic                                 r_res_valid, r_timeout;
  logic                                 w_accept, w_last_byte, w_wait_exp;

  assign w_accept    = (r_state == ST_IDLE) && go;
  assign w_last_byte = (r_idx == 5'(LOAD_BYTES-1));
  assign w_wait_exp  = (r_wcnt == CW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (go) w_next = ST_START;
      ST_START: w_next = ST_SEND;
      ST_SEND:  if (w_last_byte) w_next = ST_WAIT;
      ST_WAIT: begin
        if (mm_done)         w_next = ST_POST;
        else if (w_wait_exp) w_next = ST_IDLE;
      end
      ST_POST:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    mm_start = (r_state == ST_START);
    mm_in    = (r_state == ST_SEND) ? r_mem[r_idx] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_wcnt      <= '0;
      r_mem       <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      // Operands are frozen while a run is in flight; the go cycle is still IDLE.
      if (!busy && cfg_we && (cfg_addr < 5'(LOAD_BYTES)))
        r_mem[cfg_addr] <= cfg_wdata;
      if (w_accept) begin
        r_res_valid <= 1'b0;
        r_timeout   <= 1'b0;
      end
      case (r_state)
        ST_START: r_idx <= '0;
        ST_SEND: begin
          r_idx  <= r_idx + 5'd1;
          r_wcnt <= '0;
        end
        ST_WAIT: begin
          r_wcnt <= r_wcnt + CW'(1);
          if (!mm_done && w_wait_exp) begin
            r_timeout   <= 1'b1;
            r_res_valid <= 1'b0;
          end
        end
        ST_POST: begin
          r_res       <= w_cap;
          r_res_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Capture runs through all of WAIT; done coincides with the last result,
  // so the register holds C[0..8] when POST is entered.
  mm_result_capture #(.W(2*DATA_W), .DEPTH(MAT_ELEMS)) u_cap (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (r_state == ST_WAIT),
    .i_din   (mm_o),
    .o_words (w_cap)
  );

  assign res_data  = (res_addr < 4'(MAT_ELEMS)) ? r_res[res_addr] : '0;
  assign res_valid = r_res_valid;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_matrix_host.sv
// Directed bench for matrix_host with a cycle-accurate serial multiplier peer.
module tb_matrix_host;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [7:0]  cfg_wdata = '0;
  logic        go = 1'b0;
  logic        busy, mm_start;
  logic [7:0]  mm_in;
  logic [15:0] mm_o;
  logic        mm_done;
  logic [3:0]  res_addr = '0;
  logic [15:0] res_data;
  logic        res_valid, timeout;

  int total = 0;
  int bad   = 0;

  matrix_host #(.TIMEOUT_CYCLES(64), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .go(go), .busy(busy), .mm_start(mm_start),
    .mm_in(mm_in), .mm_o(mm_o), .mm_done(mm_done), .res_addr(res_addr),
    .res_data(res_data), .res_valid(res_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Peer: latches bytes in cycles 2-19 after start (cycle 1), streams C in 23-31.
  logic       peer_en = 1'b1;
  int         pc;
  logic [7:0] pb [18];

  function automatic logic [15:0] pelem(int k);
    logic [31:0] s = 0;
    for (int j = 0; j < 3; j++)
      s += 32'(pb[(k/3)*3 + j]) * 32'(pb[9 + j*3 + (k%3)]);
    return s[15:0];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 0; mm_o <= '0; mm_done <= 1'b0;
      for (int i = 0; i < 18; i++) pb[i] <= '0;
    end else begin
      if (peer_en && mm_start)   pc <= 2;
      else if (pc != 0 && pc < 40) pc <= pc + 1;
      else                        pc <= 0;
      if (pc >= 2 && pc <= 19) pb[pc-2] <= mm_in;
      if (pc + 1 >= 23 && pc + 1 <= 31) begin
        mm_o <= pelem(pc + 1 - 23); mm_done <= (pc == 30);
      end else begin
        mm_o <= '0; mm_done <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [7:0]  a [9];
    logic [7:0]  b [9];
    logic [15:0] c [9];
  } vec_t;
  vec_t vt [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int v);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 5'(i);
      cfg_wdata = (i < 9) ? vt[v].a[i] : vt[v].b[i-9];
    end
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic read_res(input int v);
    for (int i = 0; i < 9; i++) begin
      res_addr = 4'(i); #1;
      chk($sformatf("res[%0d]", i), int'(res_data), int'(vt[v].c[i]));
    end
  endtask

  task automatic run_chk(input int v, input bit poke);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("start_c1", int'(mm_start), 1); chk("busy_c1", int'(busy), 1);
    chk("tmo_clr", int'(timeout), 0);   chk("rv_clr", int'(res_valid), 0);
    @(negedge clk);
    chk("byte0", int'(mm_in), int'(vt[v].a[0])); chk("start_low", int'(mm_start), 0);
    for (int cy = 3; cy <= 33; cy++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (poke && cy == 5) begin cfg_we = 1'b1; cfg_addr = 5'd5; cfg_wdata = 8'hAA; end
      if (cy == 19) chk("byte17", int'(mm_in), int'(vt[v].b[8]));
      if (cy == 20) chk("wait_in0", int'(mm_in), 0);
      if (cy == 32) begin chk("busy_post", int'(busy), 1); chk("rv_post", int'(res_valid), 0); end
      if (cy == 33) begin chk("rv_c33", int'(res_valid), 1); chk("busy_c33", int'(busy), 0); end
    end
    read_res(v);
  endtask

  initial begin
    vt[0].a = '{1,0,0, 0,1,0, 0,0,1};
    vt[0].b = '{1,2,3, 4,5,6, 7,8,9};
    vt[0].c = '{1,2,3, 4,5,6, 7,8,9};
    vt[1].a = '{255,255,255, 255,255,255, 255,255,255};
    vt[1].b = '{255,255,255, 255,255,255, 255,255,255};
    vt[1].c = '{64003,64003,64003, 64003,64003,64003, 64003,64003,64003};
    vt[2].a = '{1,2,3, 4,5,6, 7,8,9};
    vt[2].b = '{1,2,3, 4,5,6, 7,8,9};
    vt[2].c = '{30,36,42, 66,81,96, 102,126,150};
    vt[3].a = '{2,0,0, 0,3,0, 0,0,4};
    vt[3].b = '{1,1,1, 1,1,1, 1,1,1};
    vt[3].c = '{2,2,2, 3,3,3, 4,4,4};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);       chk("rst_start", int'(mm_start), 0);
    chk("rst_in", int'(mm_in), 0);        chk("rst_rv", int'(res_valid), 0);
    chk("rst_tmo", int'(timeout), 0);     chk("rst_res", int'(res_data), 0);
    reset = 1'b1;

    load(0); run_chk(0, 1'b0);
    for (int i = 9; i < 16; i++) begin
      res_addr = 4'(i); #1; chk("res_oob", int'(res_data), 0);
    end
    load(1); run_chk(1, 1'b0);

    // No done from the peer: abort exactly 64 cycles after WAIT entry (cycle 20).
    peer_en = 1'b0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("tmo_rv_clr", int'(res_valid), 0);
    for (int cy = 2; cy <= 84; cy++) begin
      @(negedge clk);
      if (cy == 83) begin chk("tmo_busy83", int'(busy), 1); chk("tmo_flag83", int'(timeout), 0); end
      if (cy == 84) begin
        chk("tmo_flag", int'(timeout), 1); chk("tmo_busy", int'(busy), 0);
        chk("tmo_rv", int'(res_valid), 0);
      end
    end
    peer_en = 1'b1;

    // Out-of-range write while idle and in-range write while busy are both dropped.
    load(2);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = 5'd20; cfg_wdata = 8'h55;
    @(negedge clk); cfg_we = 1'b0;
    run_chk(2, 1'b1);

    // Reset in the tenth SEND cycle.
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    res_addr = 4'd0; #1;
    chk("mid_busy", int'(busy), 0);  chk("mid_start", int'(mm_start), 0);
    chk("mid_in", int'(mm_in), 0);   chk("mid_rv", int'(res_valid), 0);
    chk("mid_tmo", int'(timeout), 0); chk("mid_res", int'(res_data), 0);
    reset = 1'b1;
    load(3); run_chk(3, 1'b0);

    // go held: back-to-back runs, B[0] rewritten in the idle cycle between them.
    load(0);
    @(negedge clk); go = 1'b1;
    for (int cy = 1; cy <= 66; cy++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (cy == 33) begin
        chk("b2b_rv1", int'(res_valid), 1);
        res_addr = 4'd8; #1; chk("b2b_r1", int'(res_data), 9);
        cfg_we = 1'b1; cfg_addr = 5'd9; cfg_wdata = 8'd100;
      end
      if (cy == 34) begin
        go = 1'b0;
        chk("b2b_start", int'(mm_start), 1); chk("b2b_rv_lo", int'(res_valid), 0);
      end
      if (cy == 65) chk("b2b_rv65", int'(res_valid), 0);
      if (cy == 66) chk("b2b_rv66", int'(res_valid), 1);
    end
    vt[0].c[0] = 16'd100;
    read_res(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
